// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master side drives requests and release; the slave side (the arbiter) drives the grant.
interface rr_grant_arbiter_if #(
    parameter int N   = 8,
    parameter int IDW = 3
);
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with held grants, owner release and hold timeout.
// Search starts at a pointer that moves past the owner on each release.
module rr_grant_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16,
    parameter int HW       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_grant_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam bit            HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HW-1:0] HOLD_LAST =
        HOLD_EN ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [IDW:0]  N_W       = (IDW+1)'(N);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic           valid_q, valid_d;
    logic           to_q, to_d;

    logic [2*N-1:0] req_rot;
    logic           win_ok;
    logic [IDW:0]   win_sum;
    logic [IDW-1:0] win;
    logic           owner_req;
    logic           hit_max;
    logic           release_now;

    assign req_rot     = {bus.req, bus.req} >> ptr_q;
    assign owner_req   = bus.req[id_q];
    assign hit_max     = HOLD_EN && (cnt_q == HOLD_LAST);
    assign release_now = bus.done || !owner_req || hit_max;

    // Rotating-priority search: first requester at or after ptr, wrapping.
    always_comb begin
        win_ok  = 1'b0;
        win_sum = '0;
        for (int i = 0; i < N; i++) begin
            if (!win_ok && req_rot[i]) begin
                win_ok  = 1'b1;
                win_sum = {1'b0, ptr_q} + (IDW+1)'(i);
            end
        end
        if (win_sum >= N_W) begin
            win_sum = win_sum - N_W;
        end
        win = win_sum[IDW-1:0];
    end

    // State and all registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            to_q    <= to_d;
        end
    end

    // Next state: grant on any request, drop back to idle on release.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_ok) state_d = GRANT;
            GRANT:   if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next outputs; timeout flags only a release caused by the count alone.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        valid_d = valid_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_ok) begin
                    gnt_d   = N'(1) << win;
                    id_d    = win;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);
                    to_d    = hit_max && !bus.done && owner_req;
                end else begin
                    cnt_d = cnt_q + HW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter with MAX_HOLD=4.
// Each step waits one rising edge and samples 1ns later.
module tb_rr_grant_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    rr_grant_arbiter_if #(.N(8), .IDW(3)) bus ();

    rr_grant_arbiter #(
        .N(8),
        .IDW(3),
        .MAX_HOLD(4),
        .HW(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [2:0] id);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(8'(1) << id));
        chk({tag, ".id"}, 32'(bus.gnt_id), 32'(id));
        chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'd1);
    endtask

    task automatic chk_idle(input string tag, input logic to);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'd0);
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(to));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.req  = 8'hFF;
        bus.done = 1'b0;

        // Reset held with all requests pending
        step();
        step();
        chk_idle("rst", 1'b0);
        chk("rst.id", 32'(bus.gnt_id), 32'd0);
        rst_n = 1'b1;
        step();
        chk_grant("first", 3'd0);

        // Pointer and wrap
        bus.req = 8'h00;
        do_reset();
        bus.req = 8'hC0;
        step();
        chk_grant("wrap1", 3'd6);
        bus.done = 1'b1;
        step();
        chk_idle("wrap1.gap", 1'b0);
        bus.done = 1'b0;
        step();
        chk_grant("wrap2", 3'd7);
        bus.done = 1'b1;
        step();
        chk_idle("wrap2.gap", 1'b0);
        bus.done = 1'b0;
        step();
        chk_grant("wrap3", 3'd6);

        // Fairness: each grant lasts two cycles, then one idle cycle
        bus.req = 8'h00;
        do_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            chk_grant("fair.c1", 3'(k % 8));
            step();
            chk_grant("fair.c2", 3'(k % 8));
            bus.done = 1'b1;
            step();
            chk_idle("fair.gap", 1'b0);
            bus.done = 1'b0;
        end

        // Timeout: pointer is now 1, only requester 2 active
        bus.req = 8'h04;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_grant("hold", 3'd2);
            chk("hold.timeout", 32'(bus.timeout), 32'd0);
        end
        step();
        chk_idle("tmo", 1'b1);
        step();
        chk_grant("regrant", 3'd2);
        chk("regrant.timeout", 32'(bus.timeout), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk_grant("hold2", 3'd2);
        end
        bus.done = 1'b1;
        step();
        chk_idle("done_and_max", 1'b0);
        bus.done = 1'b0;

        // Request drop: pointer is now 3
        bus.req = 8'h08;
        step();
        chk_grant("drop", 3'd3);
        step();
        chk_grant("drop.hold", 3'd3);
        bus.req = 8'h00;
        step();
        chk_idle("drop.rel", 1'b0);
        bus.req = 8'h09;
        step();
        chk_grant("after_drop", 3'd0);

        // Asynchronous reset in the middle of a grant
        bus.done = 1'b1;
        step();
        chk_idle("pre_async", 1'b0);
        bus.done = 1'b0;
        bus.req  = 8'h20;
        step();
        chk_grant("async.pre", 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async", 1'b0);
        chk("async.id", 32'(bus.gnt_id), 32'd0);
        bus.req = 8'h22;
        rst_n   = 1'b1;
        step();
        chk_grant("async.post", 3'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
